ant_buf_wr_sched: RTL and testbench

// - Write-side scheduler for the even/odd antenna ping-pong buffer: turns the raw per-symbol IQ stream into addressed, bank-tagged writes.
// - Generates RE address 0..RE_NUM-1 and the last flag. Alternates banks per completed symbol. Tracks per-bank slot credits returned by the reader.
// - Drops whole symbols when the target bank has no free slot. Sits between the CPRI/FFT deinterleaver and the buffer write port.

---
 rtl/ant_buf_wr_sched.sv | 187 ++++++++++++++++++
 tb/tb_ant_buf_wr_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_buf_wr_sched.sv
// Write-side scheduler for the even/odd antenna ping-pong buffer: addresses REs, tags banks, tracks slot credits.
// Optional statistics (drop/length-error counters, credit-error flag) built only when ANT_BUF_SCHED_STAT_EN is defined.
module ant_buf_wr_sched #(
  parameter int ANT        = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int RE_NUM     = 1584,
  parameter int SLOT_NUM   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ANT*32-1:0]     i_data,
  input  logic                  i_vld,
  input  logic                  i_sop,
  input  logic                  i_rd_done,
  output logic [ADDR_WIDTH-1:0] o_iq_addr,
  output logic [ANT*32-1:0]     o_iq_data,
  output logic                  o_iq_vld,
  output logic                  o_iq_last,
  output logic                  o_bank,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic [CNT_WIDTH-1:0]  o_len_err_cnt,
  output logic                  o_credit_err
);

  localparam int CW = (SLOT_NUM < 1) ? 1 : $clog2(SLOT_NUM + 1);
  localparam logic [CW-1:0]         CRED_FULL = CW'(SLOT_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RE_NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_DROP} state_t;

  state_t                  state_q, state_d;
  logic                    bank_q, bank_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]           cred_even_q, cred_even_d;
  logic [CW-1:0]           cred_odd_q, cred_odd_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ANT*32-1:0]       data_q;
  logic                    vld_q, last_q, obank_q;

  logic                    wr_en, wr_last, commit, drop_start, len_err, credit_ovf;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [CW-1:0]           cred_cur;
  logic                    dec_even, dec_odd;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    wr_addr    = '0;
    commit     = 1'b0;
    drop_start = 1'b0;
    len_err    = 1'b0;
    cred_cur   = bank_q ? cred_odd_q : cred_even_q;

    case (state_q)
      ST_IDLE, ST_DROP: begin
        if (i_vld) begin
          // Admission is decided only at sop; a sop inside a drop re-arbitrates immediately.
          if (i_sop) begin
            cnt_d = ADDR_WIDTH'(1);
            if (cred_cur != '0) begin
              wr_en   = 1'b1;
              state_d = ST_WR;
            end else begin
              drop_start = 1'b1;
              state_d    = ST_DROP;
            end
          end else if (state_q == ST_DROP) begin
            if (cnt_q == LAST_ADDR) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      ST_WR: begin
        if (i_vld) begin
          wr_en = 1'b1;
          if (i_sop) begin
            len_err = 1'b1;
            cnt_d   = ADDR_WIDTH'(1);
          end else if (cnt_q == LAST_ADDR) begin
            wr_addr = cnt_q;
            wr_last = 1'b1;
            commit  = 1'b1;
            bank_d  = ~bank_q;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            wr_addr = cnt_q;
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit and reader release on the same bank cancel; otherwise credits saturate at SLOT_NUM.
  always_comb begin
    dec_even    = commit & ~bank_q;
    dec_odd     = commit & bank_q;
    cred_even_d = cred_even_q;
    cred_odd_d  = cred_odd_q;
    if (dec_even && !i_rd_done)
      cred_even_d = cred_even_q - CW'(1);
    else if (i_rd_done && !dec_even && cred_even_q != CRED_FULL)
      cred_even_d = cred_even_q + CW'(1);
    if (dec_odd && !i_rd_done)
      cred_odd_d = cred_odd_q - CW'(1);
    else if (i_rd_done && !dec_odd && cred_odd_q != CRED_FULL)
      cred_odd_d = cred_odd_q + CW'(1);
    credit_ovf = i_rd_done & ((~dec_even & (cred_even_q == CRED_FULL)) |
                              (~dec_odd  & (cred_odd_q  == CRED_FULL)));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      bank_q      <= 1'b0;
      cnt_q       <= '0;
      cred_even_q <= CRED_FULL;
      cred_odd_q  <= CRED_FULL;
      addr_q      <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      obank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      cnt_q       <= cnt_d;
      cred_even_q <= cred_even_d;
      cred_odd_q  <= cred_odd_d;
      addr_q      <= wr_addr;
      data_q      <= i_data;
      vld_q       <= wr_en;
      last_q      <= wr_last;
      obank_q     <= wr_en & bank_q;
    end
  end

  assign o_iq_addr = addr_q;
  assign o_iq_data = data_q;
  assign o_iq_vld  = vld_q;
  assign o_iq_last = last_q;
  assign o_bank    = obank_q;
  assign o_busy    = (state_q != ST_IDLE);

`ifdef ANT_BUF_SCHED_STAT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q, len_err_cnt_q;
  logic                 credit_err_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      drop_cnt_q    <= '0;
      len_err_cnt_q <= '0;
      credit_err_q  <= 1'b0;
    end else begin
      if (drop_start) drop_cnt_q    <= sat_inc(drop_cnt_q);
      if (len_err)    len_err_cnt_q <= sat_inc(len_err_cnt_q);
      if (credit_ovf) credit_err_q  <= 1'b1;
    end
  end

  assign o_drop_cnt    = drop_cnt_q;
  assign o_len_err_cnt = len_err_cnt_q;
  assign o_credit_err  = credit_err_q;
`else
  logic stat_unused;
  assign stat_unused   = drop_start ^ len_err ^ credit_ovf;
  assign o_drop_cnt    = '0;
  assign o_len_err_cnt = '0;
  assign o_credit_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ant_buf_wr_sched.sv
// Directed bench for ant_buf_wr_sched with RE_NUM=8, SLOT_NUM=2; statistics expectations follow ANT_BUF_SCHED_STAT_EN.
module tb_ant_buf_wr_sched;
  localparam int ANT = 4;
  localparam int AW  = 11;
  localparam int RE  = 8;
  localparam int SN  = 2;
  localparam int CNW = 16;
  localparam int DW  = ANT * 32;
`ifdef ANT_BUF_SCHED_STAT_EN
  localparam logic STAT = 1'b1;
`else
  localparam logic STAT = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic            i_vld = 1'b0;
  logic            i_sop = 1'b0;
  logic            i_rd_done = 1'b0;
  logic [AW-1:0]   o_iq_addr;
  logic [DW-1:0]   o_iq_data;
  logic            o_iq_vld, o_iq_last, o_bank, o_busy, o_credit_err;
  logic [CNW-1:0]  o_drop_cnt, o_len_err_cnt;

  ant_buf_wr_sched #(.ANT(ANT), .ADDR_WIDTH(AW), .RE_NUM(RE), .SLOT_NUM(SN), .CNT_WIDTH(CNW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_vld(i_vld), .i_sop(i_sop),
    .i_rd_done(i_rd_done), .o_iq_addr(o_iq_addr), .o_iq_data(o_iq_data), .o_iq_vld(o_iq_vld),
    .o_iq_last(o_iq_last), .o_bank(o_bank), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt),
    .o_len_err_cnt(o_len_err_cnt), .o_credit_err(o_credit_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int nvec = 0;
  int nerr = 0;
  logic [DW-1:0]   exp_data;
  logic [AW+2:0]   obs_out [RE];
  logic            obs_busy [RE];
  logic            dok_all, gap_busy_all, gap_vld_any;

  // one clock of stimulus; outputs for this beat are visible on return
  task automatic cyc(input logic vld, input logic sop, input logic rd);
    i_vld = vld; i_sop = sop; i_rd_done = rd;
    i_data = {$urandom, $urandom, $urandom, $urandom};
    exp_data = i_data;
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_vld = 1'b0; i_sop = 1'b0; i_rd_done = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  // drives one RE beat sequence with sop on beat 0 and records the outputs per beat
  task automatic run_sym(input int gap, input logic rd_last);
    dok_all = 1'b1; gap_busy_all = 1'b1; gap_vld_any = 1'b0;
    for (int k = 0; k < RE; k++) begin
      cyc(1'b1, k == 0, rd_last && (k == RE - 1));
      obs_out[k]  = {o_iq_vld, o_iq_last, o_bank, o_iq_addr};
      obs_busy[k] = o_busy;
      dok_all     = dok_all & (o_iq_data === exp_data);
      if (k < RE - 1)
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'b0, 1'b0);
          gap_busy_all = gap_busy_all & o_busy;
          gap_vld_any  = gap_vld_any | o_iq_vld;
        end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [AW+DW+4+2*CNW-1:0] got;
    do_reset();
    cyc(1'b1, 1'b1, 1'b0);
    i_reset = 1'b1; #1;
    got = {o_iq_addr, o_iq_data, o_iq_vld, o_iq_last, o_bank, o_busy, o_drop_cnt, o_len_err_cnt, o_credit_err};
    nvec++;
    if (got !== '0) begin nerr++; $display("FAIL reset_async: got %h want 0", got); end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    got = {o_iq_addr, o_iq_data, o_iq_vld, o_iq_last, o_bank, o_busy, o_drop_cnt, o_len_err_cnt, o_credit_err};
    nvec++;
    if (got !== '0) begin nerr++; $display("FAIL reset_hold: got %h want 0", got); end
  endtask

  task automatic test_single();
    logic [AW+2:0] e;
    do_reset();
    run_sym(0, 1'b0);
    for (int k = 0; k < RE; k++) begin
      e = {1'b1, 1'(k == RE - 1), 1'b0, AW'(k)};
      nvec++;
      if (obs_out[k] !== e) begin nerr++; $display("FAIL single_beat%0d: got %h want %h", k, obs_out[k], e); end
      nvec++;
      if (obs_busy[k] !== (k != RE - 1)) begin
        nerr++; $display("FAIL single_busy%0d: got %b want %b", k, obs_busy[k], (k != RE - 1));
      end
    end
    nvec++;
    if (dok_all !== 1'b1) begin nerr++; $display("FAIL single_data: got %b want 1", dok_all); end
    nvec++;
    if (o_iq_vld !== 1'b0) begin nerr++; $display("FAIL single_idle_vld: got %b want 0", o_iq_vld); end
  endtask

  task automatic test_drop();
    logic [AW+2:0] e;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      run_sym(0, 1'b0);
      for (int k = 0; k < RE; k++) begin
        e = {1'b1, 1'(k == RE - 1), 1'(s % 2), AW'(k)};
        nvec++;
        if (obs_out[k] !== e) begin nerr++; $display("FAIL drop_sym%0d_beat%0d: got %h want %h", s, k, obs_out[k], e); end
      end
    end
    run_sym(0, 1'b0);
    for (int k = 0; k < RE; k++) begin
      nvec++;
      if (obs_out[k] !== '0) begin nerr++; $display("FAIL drop_nowrite%0d: got %h want 0", k, obs_out[k]); end
    end
    nvec++;
    if ({obs_busy[0], obs_busy[RE-1]} !== 2'b10) begin
      nerr++; $display("FAIL drop_busy: got %b%b want 10", obs_busy[0], obs_busy[RE-1]);
    end
    nvec++;
    if (o_drop_cnt !== CNW'(STAT)) begin nerr++; $display("FAIL drop_cnt: got %0d want %0d", o_drop_cnt, STAT); end
    cyc(1'b0, 1'b0, 1'b1);
    run_sym(0, 1'b0);
    for (int k = 0; k < RE; k++) begin
      e = {1'b1, 1'(k == RE - 1), 1'b0, AW'(k)};
      nvec++;
      if (obs_out[k] !== e) begin nerr++; $display("FAIL drop_rescue%0d: got %h want %h", k, obs_out[k], e); end
    end
    nvec++;
    if ({o_drop_cnt, o_credit_err} !== {CNW'(STAT), 1'b0}) begin
      nerr++; $display("FAIL drop_final: got %0d/%b want %0d/0", o_drop_cnt, o_credit_err, STAT);
    end
  endtask

  task automatic test_len_err();
    logic [AW+2:0] got, e;
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, 1'b0);
    got = {o_iq_vld, o_iq_last, o_bank, o_iq_addr};
    e = {3'b100, AW'(4)};
    nvec++;
    if (got !== e) begin nerr++; $display("FAIL lenerr_pre: got %h want %h", got, e); end
    for (int k = 0; k < RE; k++) begin
      cyc(1'b1, k == 0, 1'b0);
      got = {o_iq_vld, o_iq_last, o_bank, o_iq_addr};
      e = {1'b1, 1'(k == RE - 1), 1'b0, AW'(k)};
      nvec++;
      if (got !== e) begin nerr++; $display("FAIL lenerr_restart%0d: got %h want %h", k, got, e); end
    end
    nvec++;
    if (o_len_err_cnt !== CNW'(STAT)) begin nerr++; $display("FAIL lenerr_cnt: got %0d want %0d", o_len_err_cnt, STAT); end
    run_sym(0, 1'b0);
    e = {3'b111, AW'(RE - 1)};
    nvec++;
    if (obs_out[RE-1] !== e) begin nerr++; $display("FAIL lenerr_odd: got %h want %h", obs_out[RE-1], e); end
    run_sym(0, 1'b0);
    e = {3'b110, AW'(RE - 1)};
    nvec++;
    if (obs_out[RE-1] !== e) begin nerr++; $display("FAIL lenerr_credit_once: got %h want %h", obs_out[RE-1], e); end
  endtask

  task automatic test_gap();
    logic [AW+2:0] e;
    do_reset();
    run_sym(2, 1'b0);
    for (int k = 0; k < RE; k++) begin
      e = {1'b1, 1'(k == RE - 1), 1'b0, AW'(k)};
      nvec++;
      if (obs_out[k] !== e) begin nerr++; $display("FAIL gap_beat%0d: got %h want %h", k, obs_out[k], e); end
    end
    nvec++;
    if ({gap_busy_all, gap_vld_any, obs_busy[0], obs_busy[RE-1]} !== 4'b1010) begin
      nerr++;
      $display("FAIL gap_busy: got %b%b%b%b want 1010", gap_busy_all, gap_vld_any, obs_busy[0], obs_busy[RE-1]);
    end
  endtask

  task automatic test_credit();
    logic [AW+2:0] e;
    do_reset();
    for (int s = 0; s < 3; s++) run_sym(0, 1'b0);
    run_sym(0, 1'b1);
    e = {3'b111, AW'(RE - 1)};
    nvec++;
    if (obs_out[RE-1] !== e) begin nerr++; $display("FAIL credit_coinc_last: got %h want %h", obs_out[RE-1], e); end
    nvec++;
    if (o_credit_err !== 1'b0) begin nerr++; $display("FAIL credit_coinc_err: got %b want 0", o_credit_err); end
    run_sym(0, 1'b0);
    e = {3'b100, AW'(0)};
    nvec++;
    if (obs_out[0] !== e) begin nerr++; $display("FAIL credit_even_freed: got %h want %h", obs_out[0], e); end
    run_sym(0, 1'b0);
    e = {3'b101, AW'(0)};
    nvec++;
    if (obs_out[0] !== e) begin nerr++; $display("FAIL credit_odd_kept: got %h want %h", obs_out[0], e); end
    run_sym(0, 1'b0);
    nvec++;
    if (obs_out[0] !== '0) begin nerr++; $display("FAIL credit_even_empty: got %h want 0", obs_out[0]); end

    do_reset();
    cyc(1'b0, 1'b0, 1'b1);
    nvec++;
    if (o_credit_err !== STAT) begin nerr++; $display("FAIL credit_err_set: got %b want %b", o_credit_err, STAT); end
    for (int s = 0; s < 5; s++) begin
      run_sym(0, 1'b0);
      e = (s < 4) ? {2'b10, 1'(s % 2), AW'(0)} : '0;
      nvec++;
      if (obs_out[0] !== e) begin nerr++; $display("FAIL credit_sat_sym%0d: got %h want %h", s, obs_out[0], e); end
    end
    nvec++;
    if (o_credit_err !== STAT) begin nerr++; $display("FAIL credit_err_sticky: got %b want %b", o_credit_err, STAT); end
  endtask

  task automatic test_reset_mid();
    logic [AW+2:0] got, e;
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, 1'b0);
    i_vld = 1'b1; i_sop = 1'b0;
    i_reset = 1'b1; #1;
    got = {o_iq_vld, o_iq_last, o_bank, o_iq_addr};
    nvec++;
    if ({got, o_busy, o_iq_data} !== '0) begin
      nerr++; $display("FAIL midrst_out: got %h/%b want 0/0", got, o_busy);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_vld = 1'b0;
    for (int s = 0; s < 3; s++) begin
      run_sym(0, 1'b0);
      for (int k = 0; k < RE; k++) begin
        e = {1'b1, 1'(k == RE - 1), 1'(s % 2), AW'(k)};
        nvec++;
        if (obs_out[k] !== e) begin nerr++; $display("FAIL midrst_sym%0d_beat%0d: got %h want %h", s, k, obs_out[k], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_len_err();
    test_gap();
    test_credit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
